// File: rtl/hot_addr_reporter.sv
// hot_addr_reporter: keeps a live top-K table of hot addresses built from sketch
// count updates. An accepted query snapshots and clears the live table, then the
// snapshot's valid addresses are streamed out one per handshake, in slot order.
module hot_addr_reporter #(
  parameter int TOP_K     = 5,
  parameter int ADDR_SIZE = 28,
  parameter int CNT_SIZE  = 13,
  parameter int IDX_BITS  = 3
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 upd_en,
  input  logic [ADDR_SIZE-1:0] upd_addr,
  input  logic [CNT_SIZE-1:0]  upd_cnt,
  input  logic                 query_en,
  output logic                 query_ready,
  output logic                 mig_addr_en,
  output logic [ADDR_SIZE-1:0] mig_addr,
  input  logic                 mig_addr_ready,
  output logic                 mig_last,
  output logic [IDX_BITS:0]    live_cnt
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_STREAM = 1'b1;

  // Live table: valid bits are reset, payload is plain storage.
  logic [TOP_K-1:0]     live_valid_reg;
  logic [TOP_K-1:0]     live_valid_next;
  logic [TOP_K-1:0]     base_valid;
  logic [ADDR_SIZE-1:0] live_addr_reg  [TOP_K];
  logic [ADDR_SIZE-1:0] live_addr_next [TOP_K];
  logic [CNT_SIZE-1:0]  entry_cnt_reg  [TOP_K];
  logic [CNT_SIZE-1:0]  entry_cnt_next [TOP_K];
  logic [TOP_K-1:0]     match_vec;
  logic [IDX_BITS:0]    valid_total_reg;
  logic [IDX_BITS:0]    valid_total_next;

  // Snapshot taken at query accept; never touched by live updates.
  logic [TOP_K-1:0]     snap_valid_reg;
  logic [ADDR_SIZE-1:0] snap_addr_reg [TOP_K];

  logic [0:0]           state_reg;
  logic [IDX_BITS-1:0]  ptr_reg;
  logic                 query_ready_reg;
  logic                 mig_en_reg;
  logic [ADDR_SIZE-1:0] mig_addr_reg;
  logic                 mig_last_reg;

  logic accept;
  logic handshake;

  // Update-target search results.
  logic hit_found;
  logic free_found;
  int   hit_idx;
  int   free_idx;
  int   min_idx;

  // First valid live entry (start of a new stream) and next valid snapshot entry.
  logic live_first_found;
  logic live_more_found;
  int   live_first_idx;
  logic snap_next_found;
  logic snap_after_found;
  int   snap_next_idx;

  assign accept    = (state_reg == ST_IDLE) && query_ready_reg && query_en;
  assign handshake = (state_reg == ST_STREAM) && mig_en_reg && mig_addr_ready;

  assign query_ready = query_ready_reg;
  assign mig_addr_en = mig_en_reg;
  assign mig_addr    = mig_addr_reg;
  assign mig_last    = mig_last_reg;
  assign live_cnt    = valid_total_reg;

  genvar gi;
  generate
    for (gi = 0; gi < TOP_K; gi++) begin : g_entry
      assign match_vec[gi] = live_valid_reg[gi] && (live_addr_reg[gi] == upd_addr);

      // Per-entry payload storage for the live table and the snapshot.
      always_ff @(posedge clk) begin
        live_addr_reg[gi] <= live_addr_next[gi];
        entry_cnt_reg[gi] <= entry_cnt_next[gi];
        if (accept) begin
          snap_addr_reg[gi] <= live_addr_reg[gi];
        end
      end
    end
  endgenerate

  // Apply one count update to the live table (cleared first when a query is accepted).
  always_comb begin
    base_valid      = accept ? '0 : live_valid_reg;
    live_valid_next = base_valid;
    for (int i = 0; i < TOP_K; i++) begin
      live_addr_next[i] = live_addr_reg[i];
      entry_cnt_next[i] = entry_cnt_reg[i];
    end
    hit_found  = 1'b0;
    free_found = 1'b0;
    hit_idx    = 0;
    free_idx   = 0;
    min_idx    = 0;
    for (int i = 0; i < TOP_K; i++) begin
      if (match_vec[i] && !accept && !hit_found) begin
        hit_found = 1'b1;
        hit_idx   = i;
      end
      if (!base_valid[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = i;
      end
      // Strict compare keeps the lowest index on ties.
      if (entry_cnt_reg[i] < entry_cnt_reg[min_idx]) begin
        min_idx = i;
      end
    end
    if (upd_en) begin
      if (hit_found) begin
        entry_cnt_next[hit_idx] = upd_cnt;
      end else if (free_found) begin
        live_valid_next[free_idx] = 1'b1;
        live_addr_next[free_idx]  = upd_addr;
        entry_cnt_next[free_idx]  = upd_cnt;
      end else if (upd_cnt > entry_cnt_reg[min_idx]) begin
        live_addr_next[min_idx] = upd_addr;
        entry_cnt_next[min_idx] = upd_cnt;
      end
    end
  end

  // Population count of the next live valid vector, registered as live_cnt.
  always_comb begin
    valid_total_next = '0;
    for (int i = 0; i < TOP_K; i++) begin
      valid_total_next = valid_total_next + {{IDX_BITS{1'b0}}, live_valid_next[i]};
    end
  end

  // Locate the first valid live entry and the next valid snapshot entry above ptr.
  always_comb begin
    live_first_found = 1'b0;
    live_more_found  = 1'b0;
    live_first_idx   = 0;
    snap_next_found  = 1'b0;
    snap_after_found = 1'b0;
    snap_next_idx    = 0;
    for (int i = 0; i < TOP_K; i++) begin
      if (live_valid_reg[i]) begin
        if (!live_first_found) begin
          live_first_found = 1'b1;
          live_first_idx   = i;
        end else begin
          live_more_found = 1'b1;
        end
      end
      if (snap_valid_reg[i] && (i > int'(ptr_reg))) begin
        if (!snap_next_found) begin
          snap_next_found = 1'b1;
          snap_next_idx   = i;
        end else begin
          snap_after_found = 1'b1;
        end
      end
    end
  end

  // Query/stream control and registered stream outputs.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      live_valid_reg  <= '0;
      valid_total_reg <= '0;
      snap_valid_reg  <= '0;
      state_reg       <= ST_IDLE;
      ptr_reg         <= '0;
      query_ready_reg <= 1'b0;
      mig_en_reg      <= 1'b0;
      mig_addr_reg    <= '0;
      mig_last_reg    <= 1'b0;
    end else begin
      live_valid_reg  <= live_valid_next;
      valid_total_reg <= valid_total_next;
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            snap_valid_reg  <= live_valid_reg;
            query_ready_reg <= 1'b0;
            if (live_first_found) begin
              state_reg    <= ST_STREAM;
              ptr_reg      <= IDX_BITS'(live_first_idx);
              mig_en_reg   <= 1'b1;
              mig_addr_reg <= live_addr_reg[live_first_idx];
              mig_last_reg <= !live_more_found;
            end else begin
              ptr_reg <= '0;
            end
          end else if (!query_ready_reg) begin
            query_ready_reg <= 1'b1;
          end
        end
        default: begin
          if (handshake) begin
            if (mig_last_reg || !snap_next_found) begin
              state_reg       <= ST_IDLE;
              mig_en_reg      <= 1'b0;
              mig_last_reg    <= 1'b0;
              query_ready_reg <= 1'b1;
            end else begin
              ptr_reg      <= IDX_BITS'(snap_next_idx);
              mig_addr_reg <= snap_addr_reg[snap_next_idx];
              mig_last_reg <= !snap_after_found;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hot_addr_reporter.sv
// tb_hot_addr_reporter: directed scenarios followed by random traffic, all checked
// cycle by cycle against a list-based reference of the top-K table and query stream.
module tb_hot_addr_reporter;
  localparam int TOP_K     = 5;
  localparam int ADDR_SIZE = 28;
  localparam int CNT_SIZE  = 13;
  localparam int IDX_BITS  = 3;

  logic                 clk = 1'b0;
  logic                 rstn = 1'b0;
  logic                 upd_en = 1'b0;
  logic [ADDR_SIZE-1:0] upd_addr = '0;
  logic [CNT_SIZE-1:0]  upd_cnt = '0;
  logic                 query_en = 1'b0;
  logic                 query_ready;
  logic                 mig_addr_en;
  logic [ADDR_SIZE-1:0] mig_addr;
  logic                 mig_addr_ready = 1'b0;
  logic                 mig_last;
  logic [IDX_BITS:0]    live_cnt;

  int checks_total  = 0;
  int checks_passed = 0;

  // Reference state.
  logic                 m_valid [TOP_K];
  logic [ADDR_SIZE-1:0] m_addr  [TOP_K];
  logic [CNT_SIZE-1:0]  m_cnt   [TOP_K];
  logic [ADDR_SIZE-1:0] m_stream [$];
  logic                 exp_qr = 1'b0;
  logic                 exp_en = 1'b0;

  hot_addr_reporter #(
    .TOP_K(TOP_K), .ADDR_SIZE(ADDR_SIZE), .CNT_SIZE(CNT_SIZE), .IDX_BITS(IDX_BITS)
  ) dut (
    .clk(clk), .rstn(rstn), .upd_en(upd_en), .upd_addr(upd_addr), .upd_cnt(upd_cnt),
    .query_en(query_en), .query_ready(query_ready), .mig_addr_en(mig_addr_en),
    .mig_addr(mig_addr), .mig_addr_ready(mig_addr_ready), .mig_last(mig_last),
    .live_cnt(live_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_total++;
    assert (obs === exp) checks_passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Top-K insertion rules: refresh a match, else fill lowest free, else evict a smaller minimum.
  task automatic model_update(input logic [ADDR_SIZE-1:0] a, input logic [CNT_SIZE-1:0] c);
    int hit = -1;
    int free = -1;
    int mi = 0;
    for (int i = 0; i < TOP_K; i++) begin
      if (m_valid[i] && m_addr[i] == a) hit = i;
      if (!m_valid[i] && free < 0) free = i;
    end
    if (hit >= 0) begin
      m_cnt[hit] = c;
    end else if (free >= 0) begin
      m_valid[free] = 1'b1;
      m_addr[free]  = a;
      m_cnt[free]   = c;
    end else begin
      for (int i = 1; i < TOP_K; i++) if (m_cnt[i] < m_cnt[mi]) mi = i;
      if (c > m_cnt[mi]) begin
        m_addr[mi] = a;
        m_cnt[mi]  = c;
      end
    end
  endtask

  // What the block should do at this clock edge, given the inputs presented to it.
  task automatic model_edge();
    if (!rstn) begin
      for (int i = 0; i < TOP_K; i++) m_valid[i] = 1'b0;
      m_stream.delete();
      exp_qr = 1'b0;
      exp_en = 1'b0;
    end else begin
      if (exp_qr && query_en) begin
        m_stream.delete();
        for (int i = 0; i < TOP_K; i++) if (m_valid[i]) m_stream.push_back(m_addr[i]);
        for (int i = 0; i < TOP_K; i++) m_valid[i] = 1'b0;
        exp_qr = 1'b0;
        exp_en = (m_stream.size() > 0);
      end else if (exp_en) begin
        if (mig_addr_ready) begin
          void'(m_stream.pop_front());
          if (m_stream.size() == 0) begin
            exp_en = 1'b0;
            exp_qr = 1'b1;
          end
        end
      end else if (!exp_qr) begin
        exp_qr = 1'b1;
      end
      if (upd_en) model_update(upd_addr, upd_cnt);
    end
  endtask

  function automatic int model_count();
    int n = 0;
    for (int i = 0; i < TOP_K; i++) if (m_valid[i]) n++;
    return n;
  endfunction

  task automatic compare_all();
    check("query_ready", 32'(query_ready), 32'(exp_qr));
    check("mig_addr_en", 32'(mig_addr_en), 32'(exp_en));
    check("live_cnt", 32'(live_cnt), 32'(model_count()));
    if (exp_en) begin
      check("mig_addr", 32'(mig_addr), 32'(m_stream[0]));
      check("mig_last", 32'(mig_last), 32'(m_stream.size() == 1));
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
    $display("cyc rstn=%0b upd=%0b:%0h/%0d q=%0b rdy=%0b -> qr=%0b en=%0b addr=%0h last=%0b cnt=%0d",
             rstn, upd_en, upd_addr, upd_cnt, query_en, mig_addr_ready,
             query_ready, mig_addr_en, mig_addr, mig_last, live_cnt);
  endtask

  task automatic do_upd(input logic [ADDR_SIZE-1:0] a, input logic [CNT_SIZE-1:0] c);
    upd_en = 1'b1; upd_addr = a; upd_cnt = c;
    step();
    upd_en = 1'b0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    step();
    rstn = 1'b1;
  endtask

  task automatic do_query();
    query_en = 1'b1;
    step();
    query_en = 1'b0;
  endtask

  // Run cycles until the stream drains; an exhausted budget counts as a failure.
  task automatic drain(input int budget);
    int n = 0;
    while (exp_en && n < budget) begin
      step();
      n++;
    end
    check("drain_timeout", 32'(exp_en), 32'(0));
  endtask

  initial begin
    for (int i = 0; i < TOP_K; i++) begin
      m_valid[i] = 1'b0; m_addr[i] = '0; m_cnt[i] = '0;
    end

    // Reset values, then three updates without a query.
    do_reset();
    check("reset_mig_addr", 32'(mig_addr), 32'(0));
    check("reset_mig_last", 32'(mig_last), 32'(0));
    do_upd(28'hA0, 13'd5);
    do_upd(28'hA1, 13'd9);
    do_upd(28'hA2, 13'd3);
    step();
    check("t1_live_cnt", 32'(live_cnt), 32'(3));

    // Eviction of the minimum and a dropped update; streamed back in slot order.
    do_reset();
    do_upd(28'h10, 13'd4);
    do_upd(28'h11, 13'd7);
    do_upd(28'h12, 13'd2);
    do_upd(28'h13, 13'd9);
    do_upd(28'h14, 13'd6);
    do_upd(28'hABC, 13'd3);
    do_upd(28'hDEF, 13'd1);
    check("t2_live_cnt", 32'(live_cnt), 32'(5));
    mig_addr_ready = 1'b1;
    do_query();
    check("t2_first_addr", 32'(mig_addr), 32'h10);
    step();
    step();
    check("t2_evicted_slot", 32'(mig_addr), 32'hABC);
    drain(20);
    check("t2_ready_back", 32'(query_ready), 32'(1));

    // Stall with mig_addr_ready low for four cycles mid-stream.
    do_upd(28'h21, 13'd1);
    do_upd(28'h22, 13'd2);
    do_upd(28'h23, 13'd3);
    mig_addr_ready = 1'b0;
    do_query();
    mig_addr_ready = 1'b1;
    step();
    mig_addr_ready = 1'b0;
    repeat (4) step();
    check("t4_held_addr", 32'(mig_addr), 32'h22);
    mig_addr_ready = 1'b1;
    drain(20);

    // Empty query, then a query coincident with an update.
    step();
    do_query();
    check("t5_empty_ready_low", 32'(query_ready), 32'(0));
    step();
    check("t5_empty_ready_back", 32'(query_ready), 32'(1));
    upd_en = 1'b1; upd_addr = 28'h55; upd_cnt = 13'd8;
    do_query();
    upd_en = 1'b0;
    check("t5_coincident_cnt", 32'(live_cnt), 32'(1));
    step();
    do_query();
    check("t5_slot0_addr", 32'(mig_addr), 32'h55);
    drain(20);

    // Reset mid-stream after the first of three addresses.
    do_upd(28'h31, 13'd1);
    do_upd(28'h32, 13'd2);
    do_upd(28'h33, 13'd3);
    do_query();
    step();
    do_reset();
    check("t6_en_after_reset", 32'(mig_addr_en), 32'(0));
    step();
    check("t6_ready_after_release", 32'(query_ready), 32'(1));

    // Random traffic over a small address pool so matches, ties and evictions all occur.
    for (int n = 0; n < 1500; n++) begin
      rstn           = ($urandom_range(0, 199) != 0);
      upd_en         = ($urandom_range(0, 99) < 60);
      upd_addr       = ADDR_SIZE'($urandom_range(0, 11));
      upd_cnt        = CNT_SIZE'($urandom_range(0, 15));
      query_en       = ($urandom_range(0, 9) == 0);
      mig_addr_ready = ($urandom_range(0, 99) < 65);
      step();
    end
    rstn = 1'b1; upd_en = 1'b0; query_en = 1'b0; mig_addr_ready = 1'b1;
    drain(20);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end
endmodule
